cla_nibble_serial_adder: RTL and testbench

- Sequential wide adder that reuses one 4-bit carry-lookahead slice, adding one nibble per clock from LSB to MSB.
- A registered carry links each nibble to the next.
- Sits directly upstream of result consumers and feeds the 4-bit CLA slice (a, b, cin in; sum, cout out).
- Wraps that slice with operand capture, nibble sequencing and valid/ready handshakes, so WIDTH-bit additions run at small area.

---
 rtl/cla_nibble_serial_adder.sv | 149 ++++++++++++++
 tb/tb_cla_nibble_serial_adder.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/cla_nibble_serial_adder.sv
`default_nettype none
// ============================================================================
//  Module      : cla_nibble_serial_adder
//  Description : Adds two WIDTH-bit operands one nibble per clock through a
//                single 4-bit carry-lookahead slice. A registered carry links
//                each nibble to the next. Operands arrive and results leave
//                through valid/ready handshakes.
//  Revision    : 1.0 - initial release
// ============================================================================
module cla_nibble_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int NIB  = WIDTH / 4;
    localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;

    localparam logic [IDXW-1:0] c_last    = IDXW'(NIB - 1);
    localparam logic [IDXW-1:0] c_idx_one = IDXW'(1);

    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_run  = 2'd1;
    localparam logic [1:0] c_done = 2'd2;

    // Reject widths that cannot be split into whole nibbles.
    generate
        if ((WIDTH % 4 != 0) || (WIDTH < 4)) begin : g_bad_width
            $error("cla_nibble_serial_adder: WIDTH must be a multiple of 4 and >= 4");
        end
    endgenerate

    logic [1:0]       r_state;
    logic [1:0]       w_next_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_carry;
    logic [IDXW-1:0]  r_idx;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_overflow;
    logic             r_out_valid;

    logic [3:0]       w_a_nib;
    logic [3:0]       w_b_nib;
    logic [3:0]       w_g;
    logic [3:0]       w_p;
    logic [4:0]       w_c;
    logic [3:0]       w_slice_sum;
    logic             w_slice_cout;

    // Nibble selection: the slice only ever sees the nibble at r_idx.
    assign w_a_nib = r_a[{r_idx, 2'b00} +: 4];
    assign w_b_nib = r_b[{r_idx, 2'b00} +: 4];

    // 4-bit carry-lookahead slice; every carry is a flat sum of products.
    always_comb begin
        w_g    = w_a_nib & w_b_nib;
        w_p    = w_a_nib ^ w_b_nib;
        w_c[0] = r_carry;
        w_c[1] = w_g[0] | (w_p[0] & r_carry);
        w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & r_carry);
        w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
               | (w_p[2] & w_p[1] & w_p[0] & r_carry);
        w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
               | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
               | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & r_carry);
        w_slice_sum  = w_p ^ w_c[3:0];
        w_slice_cout = w_c[4];
    end

    // Next-state logic for the IDLE -> RUN -> DONE sequence.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_idle:  if (in_valid)        w_next_state = c_run;
            c_run:   if (r_idx == c_last) w_next_state = c_done;
            c_done:  if (out_ready)       w_next_state = c_idle;
            default:                      w_next_state = c_idle;
        endcase
    end

    // State register and the registered result-valid flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= c_idle;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_out_valid <= (w_next_state == c_done);
        end
    end

    // Datapath: capture operands on accept, then fold one nibble per cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a        <= '0;
            r_b        <= '0;
            r_carry    <= 1'b0;
            r_idx      <= '0;
            r_sum      <= '0;
            r_cout     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            case (r_state)
                c_idle: begin
                    if (in_valid) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_carry <= cin;
                        r_idx   <= '0;
                        r_sum   <= '0;
                    end
                end
                c_run: begin
                    r_sum[{r_idx, 2'b00} +: 4] <= w_slice_sum;
                    r_carry <= w_slice_cout;
                    r_idx   <= r_idx + c_idx_one;
                    if (r_idx == c_last) begin
                        r_cout     <= w_slice_cout;
                        // Carry into the MSB is recovered from the MSB sum bit.
                        r_overflow <= w_slice_cout
                                    ^ (r_a[WIDTH-1] ^ r_b[WIDTH-1] ^ w_slice_sum[3]);
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == c_idle);
    assign out_valid = r_out_valid;
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign overflow  = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_cla_nibble_serial_adder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cla_nibble_serial_adder
//  Description : Self-checking bench for cla_nibble_serial_adder (WIDTH=16).
//                Expected results come from plain wide arithmetic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cla_nibble_serial_adder;

    localparam int WIDTH = 16;
    localparam int NIB   = WIDTH / 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             overflow;

    int nvec = 0;
    int nerr = 0;
    int cyc  = 0;

    cla_nibble_serial_adder #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    // Free-running cycle count for measuring accept spacing.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One full operation. Entered and left at a negative clock edge.
    task automatic run_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_v,
                          input logic tcin, input int stall, input bit scramble,
                          input bit hold, output int acc_cyc);
        logic [WIDTH:0] full;
        logic           eov;
        full = {1'b0, ta} + {1'b0, tb_v} + {{WIDTH{1'b0}}, tcin};
        eov  = (ta[WIDTH-1] == tb_v[WIDTH-1]) && (full[WIDTH-1] != ta[WIDTH-1]);
        a = ta; b = tb_v; cin = tcin; in_valid = 1'b1; out_ready = (stall == 0);
        chk("in_ready_idle", 32'(in_ready), 32'd1);
        acc_cyc = cyc;
        @(posedge clk);
        for (int k = 0; k < NIB; k++) begin
            @(negedge clk);
            if (!hold) in_valid = 1'b0;
            if (scramble) begin
                a = WIDTH'($urandom); b = WIDTH'($urandom); cin = 1'($urandom);
            end
            chk("busy_out_valid", 32'(out_valid), 32'd0);
            chk("busy_in_ready", 32'(in_ready), 32'd0);
        end
        @(negedge clk);
        chk("done_out_valid", 32'(out_valid), 32'd1);
        chk("sum", 32'(sum), 32'(full[WIDTH-1:0]));
        chk("cout", 32'(cout), 32'(full[WIDTH]));
        chk("overflow", 32'(overflow), 32'(eov));
        for (int i = 0; i < stall; i++) begin
            in_valid = 1'b1; a = 16'hAAAA; b = 16'h0000; cin = 1'b0;
            @(negedge clk);
            chk("stall_out_valid", 32'(out_valid), 32'd1);
            chk("stall_in_ready", 32'(in_ready), 32'd0);
            chk("stall_sum", 32'(sum), 32'(full[WIDTH-1:0]));
            chk("stall_cout", 32'(cout), 32'(full[WIDTH]));
        end
        in_valid  = hold;
        out_ready = 1'b1;
        @(negedge clk);
        chk("release_out_valid", 32'(out_valid), 32'd0);
        chk("release_in_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        int acc0;
        int acc1;
        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_sum", 32'(sum), 32'd0);
        chk("reset_cout", 32'(cout), 32'd0);
        chk("reset_overflow", 32'(overflow), 32'd0);

        // Zero add and full ripple cases.
        run_op(16'h0000, 16'h0000, 1'b0, 0, 1'b0, 1'b0, acc0);
        run_op(16'hFFFF, 16'h0001, 1'b0, 0, 1'b0, 1'b0, acc0);
        run_op(16'h7FFF, 16'h0000, 1'b1, 0, 1'b0, 1'b0, acc0);

        // Backpressure with an intruding request during the stall.
        run_op(16'h1234, 16'h4321, 1'b1, 3, 1'b0, 1'b0, acc0);

        // Reset while the third nibble is being processed.
        a = 16'hFFFF; b = 16'hFFFF; cin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk); in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        chk("abort_sum", 32'(sum), 32'd0);
        chk("abort_cout", 32'(cout), 32'd0);
        chk("abort_overflow", 32'(overflow), 32'd0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("abort_no_valid", 32'(out_valid), 32'd0);
        end
        run_op(16'h00F0, 16'h0010, 1'b0, 0, 1'b0, 1'b0, acc0);

        // Back-to-back with in_valid held high: accepts six cycles apart.
        run_op(16'h8000, 16'h8000, 1'b0, 0, 1'b0, 1'b1, acc0);
        run_op(16'h0001, 16'h0001, 1'b0, 0, 1'b0, 1'b0, acc1);
        chk("accept_spacing", 32'(acc1 - acc0), 32'(NIB + 2));

        // Operands scrambled during RUN must not disturb the result.
        run_op(16'h0F0F, 16'h0101, 1'b0, 0, 1'b1, 1'b0, acc0);

        // Randomized operations with random stalls and scrambling.
        for (int n = 0; n < 24; n++) begin
            run_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom),
                   int'($urandom_range(0, 2)), 1'($urandom), 1'b0, acc0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
`default_nettype wire
